// File: rtl/core_pkg.sv
// Shared execute-stage definitions for the RV32M multiply/divide unit:
// M-extension opcode fields and the iterative unit's state encoding.
package core_pkg;

   localparam logic [6:0] FUNCT7_M      = 7'h01;

   localparam logic [2:0] FUNCT3_MUL    = 3'd0;
   localparam logic [2:0] FUNCT3_MULH   = 3'd1;
   localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
   localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
   localparam logic [2:0] FUNCT3_DIV    = 3'd4;
   localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
   localparam logic [2:0] FUNCT3_REM    = 3'd6;
   localparam logic [2:0] FUNCT3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_DONE
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// acceptance, a radix-2 shift-add multiply or restoring divide runs one bit per
// cycle, and the sign is restored on the last iteration. The result and tag are
// held until writeback takes them; flush kills whatever is in flight.
module muldiv_unit
   import core_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                in_funct3,
   input  logic [DATA_WIDTH-1:0]     in_rs1_data,
   input  logic [DATA_WIDTH-1:0]     in_rs2_data,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_result,
   output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
   output logic                      busy
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] COUNT_INIT = CW'(DATA_WIDTH - 1);
   localparam logic [W-1:0]  MOST_NEG   = {1'b1, {(W-1){1'b0}}};

   muldiv_state_e             r_state;
   muldiv_state_e             w_nextState;
   logic [CW-1:0]             r_count;
   logic [2:0]                r_funct3;
   logic [REG_ADDR_WIDTH-1:0] r_rdAddr;
   logic                      r_negResult;
   logic [W-1:0]              r_operand;
   logic [2*W-1:0]            r_acc;
   logic [W-1:0]              r_result;

   logic                      w_accept;
   logic                      w_isDiv;
   logic                      w_signedA;
   logic                      w_signedB;
   logic                      w_negA;
   logic                      w_negB;
   logic [W-1:0]              w_magA;
   logic [W-1:0]              w_magB;
   logic                      w_divZero;
   logic                      w_overflow;
   logic                      w_special;
   logic [W-1:0]              w_specialResult;
   logic                      w_negResult;
   logic [W:0]                w_mulSum;
   logic [2*W-1:0]            w_mulNext;
   logic [W:0]                w_divShift;
   logic [W:0]                w_divDiff;
   logic                      w_divGe;
   logic [2*W-1:0]            w_divNext;
   logic [2*W-1:0]            w_accNext;
   logic [2*W-1:0]            w_prodFixed;
   logic [W-1:0]              w_quotFixed;
   logic [W-1:0]              w_remFixed;
   logic [W-1:0]              w_finalResult;

   assign in_ready    = (r_state == MD_IDLE);
   assign busy        = (r_state != MD_IDLE);
   assign out_valid   = (r_state == MD_DONE);
   assign out_result  = r_result;
   assign out_rd_addr = r_rdAddr;
   assign w_accept    = (r_state == MD_IDLE) && in_valid && !flush;

   // Operand pre-conditioning: work out which operands are signed, take
   // magnitudes, and recognise the divide cases that need no iteration.
   always_comb begin
      w_isDiv    = in_funct3[2];
      w_signedA  = (in_funct3 == FUNCT3_MUL) || (in_funct3 == FUNCT3_MULH) ||
                   (in_funct3 == FUNCT3_MULHSU) || (in_funct3 == FUNCT3_DIV) ||
                   (in_funct3 == FUNCT3_REM);
      w_signedB  = (in_funct3 == FUNCT3_MUL) || (in_funct3 == FUNCT3_MULH) ||
                   (in_funct3 == FUNCT3_DIV) || (in_funct3 == FUNCT3_REM);
      w_negA     = w_signedA && in_rs1_data[W-1];
      w_negB     = w_signedB && in_rs2_data[W-1];
      w_magA     = w_negA ? -in_rs1_data : in_rs1_data;
      w_magB     = w_negB ? -in_rs2_data : in_rs2_data;
      w_divZero  = (in_rs2_data == '0);
      w_overflow = ((in_funct3 == FUNCT3_DIV) || (in_funct3 == FUNCT3_REM)) &&
                   (in_rs1_data == MOST_NEG) && (in_rs2_data == '1);
      w_special  = w_isDiv && (w_divZero || w_overflow);
      if (w_divZero) begin
         w_specialResult = in_funct3[1] ? in_rs1_data : '1;
      end else begin
         w_specialResult = in_funct3[1] ? '0 : in_rs1_data;
      end
      w_negResult = (w_isDiv && in_funct3[1]) ? w_negA : (w_negA ^ w_negB);
   end

   // One datapath iteration plus the sign fix-up applied to its outcome; the
   // accumulator holds {high, low} for multiply and {remainder, quotient} for
   // divide.
   always_comb begin
      w_mulSum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_operand : '0)};
      w_mulNext   = {w_mulSum, r_acc[W-1:1]};
      w_divShift  = {r_acc[2*W-1:W], r_acc[W-1]};
      w_divDiff   = w_divShift - {1'b0, r_operand};
      w_divGe     = !w_divDiff[W];
      w_divNext   = {(w_divGe ? w_divDiff[W-1:0] : w_divShift[W-1:0]),
                     r_acc[W-2:0], w_divGe};
      w_accNext   = r_funct3[2] ? w_divNext : w_mulNext;
      w_prodFixed = r_negResult ? -w_accNext : w_accNext;
      w_quotFixed = r_negResult ? -w_accNext[W-1:0] : w_accNext[W-1:0];
      w_remFixed  = r_negResult ? -w_accNext[2*W-1:W] : w_accNext[2*W-1:W];
      case (r_funct3)
         FUNCT3_MUL:               w_finalResult = w_prodFixed[W-1:0];
         FUNCT3_DIV, FUNCT3_DIVU:  w_finalResult = w_quotFixed;
         FUNCT3_REM, FUNCT3_REMU:  w_finalResult = w_remFixed;
         default:                  w_finalResult = w_prodFixed[2*W-1:W];
      endcase
   end

   // State register: reset dominates, everything else comes from next-state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MD_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state: accept in IDLE, count down in CALC, wait for writeback in
   // DONE; a flush overrides every transition.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         MD_IDLE: if (in_valid) w_nextState = w_special ? MD_DONE : MD_CALC;
         MD_CALC: if (r_count == '0) w_nextState = MD_DONE;
         MD_DONE: if (out_ready) w_nextState = MD_IDLE;
         default: w_nextState = MD_IDLE;
      endcase
      if (flush) begin
         w_nextState = MD_IDLE;
      end
   end

   // Datapath registers: latch the request on acceptance, iterate in CALC and
   // capture the fixed-up result on the final iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_funct3    <= '0;
         r_rdAddr    <= '0;
         r_negResult <= 1'b0;
         r_operand   <= '0;
         r_acc       <= '0;
         r_result    <= '0;
      end else if (w_accept) begin
         r_count     <= COUNT_INIT;
         r_funct3    <= in_funct3;
         r_rdAddr    <= in_rd_addr;
         r_negResult <= w_negResult;
         r_operand   <= w_isDiv ? w_magB : w_magA;
         r_acc       <= {{W{1'b0}}, (w_isDiv ? w_magA : w_magB)};
         if (w_special) begin
            r_result <= w_specialResult;
         end
      end else if ((r_state == MD_CALC) && !flush) begin
         r_acc <= w_accNext;
         if (r_count == '0) begin
            r_result <= w_finalResult;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit, parametrised in operand width, sitting beside the ALU in the execute stage. It accepts one operation at a time via a valid/ready handshake and computes all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a radix-2 shift-add / restoring-divide datapath. It holds the result and destination tag until writeback accepts it. It supports a pipeline flush that kills an in-flight operation.

## Interface
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 8
- REG_ADDR_WIDTH, 5, destination register tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- in_funct3  in  3  M-extension funct3 (decoder already qualified FUNCT7_M)
- in_rs1_data  in  DATA_WIDTH  multiplicand / dividend
- in_rs2_data  in  DATA_WIDTH  multiplier / divisor
- in_rd_addr  in  REG_ADDR_WIDTH  destination tag, passed through
- flush  in  1  kill current operation
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  DATA_WIDTH  result
- out_rd_addr  out  REG_ADDR_WIDTH  tag captured at acceptance
- busy  out  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid, latch funct3, rd_addr, operand magnitudes and result-sign flags.
  - Special division cases go straight to DONE.
  - All other operations go to CALC with the iteration counter set to DATA_WIDTH-1.
- Special division cases:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM, dividend = most-negative, divisor = −1): DIV gives the dividend; REM gives 0.
- CALC: one iteration per cycle.
  - Multiply: 2×DATA_WIDTH-bit accumulator, shift-add.
  - Divide: restoring, one quotient bit per cycle.
  - When the counter reaches 0, apply the sign fix-up and go to DONE.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Product: negate the full 2W product if the signs differ.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Result select: MUL takes the low W bits; MULH/MULHSU/MULHU take the high W bits.
- DONE: out_valid=1; out_result and out_rd_addr stay stable until out_valid && out_ready, then go to IDLE.
- flush and rst: return to IDLE at the next edge from any state; out_valid drops. Priority is rst > flush > handshake.
  - flush with in_valid in IDLE: the request is not accepted.
  - flush in DONE with out_ready high: no handshake occurs.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - busy=0
  - out_result=0
  - out_rd_addr=0
- Normal op: accepted at edge E0; out_valid rises after edge E0+DATA_WIDTH, i.e. DATA_WIDTH+1 cycles after the acceptance cycle (33 for W=32).
- Special divide cases: out_valid in the cycle after acceptance (latency 1).
- Back-to-back: the earliest next acceptance is the cycle after the output handshake. There is no overlap of DONE and accept.
- out_result is registered; no combinational path from in_* to out_*.
- in_ready is a function of state only; no dependency on in_valid.

## Structure
- core_pkg additions:
  - FUNCT7_M = 7'h01
  - FUNCT3_MUL 0, MULH 1, MULHSU 2, MULHU 3, DIV 4, DIVU 5, REM 6, REMU 7
  - typedef enum muldiv_state_e {MD_IDLE, MD_CALC, MD_DONE}
- Single module, no sub-module. Sign pre-conditioning and fix-up are local combinational logic. The counter is $clog2(DATA_WIDTH) bits.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD → out_result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance, out_rd_addr equals the input tag.
- High multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 0x0000000E; REMU → 0x00000002.
- Special cases, each with out_valid one cycle after acceptance:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_result/out_rd_addr stable, in_ready=0. Raise out_ready → in_ready=1 next cycle, and a new op is accepted.
- Kill: flush (and separately rst) asserted on the 10th CALC cycle → out_valid never rises, in_ready=1 next cycle, busy=0. A following DIVU 9/3 returns 3 normally.
